// File: rtl/seq_chk_pkg.sv
// Shared types and constants for the sequence self-check monitor.
package seq_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_FIB   = 2'd0;
    localparam logic [1:0] MODE_ARITH = 2'd1;
    localparam logic [1:0] MODE_DBL   = 2'd2;

    // Mode 3 is reserved and behaves as Fibonacci.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return ((m == MODE_ARITH) || (m == MODE_DBL)) ? m : MODE_FIB;
    endfunction

endpackage

// File: rtl/seq_gen.sv
// Reference sequence generator: holds the current expected term (exp_a) and
// the auxiliary value exp_b (next Fibonacci term, or the arithmetic step).
module seq_gen
    import seq_chk_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed0,
    input  logic [DATA_W-1:0] seed1,
    output logic [DATA_W-1:0] exp_a
);

    logic [DATA_W-1:0] exp_b;
    logic [DATA_W-1:0] next_a;
    logic [DATA_W-1:0] next_b;

    // Next-term computation; all arithmetic wraps at DATA_W bits.
    always_comb begin
        next_a = exp_a;
        next_b = exp_b;
        case (mode)
            MODE_ARITH: next_a = exp_a + exp_b;
            MODE_DBL:   next_a = exp_a << 1;
            default: begin
                next_a = exp_b;
                next_b = exp_a + exp_b;
            end
        endcase
    end

    // Term registers: load wins over advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_a <= '0;
            exp_b <= '0;
        end else if (load) begin
            exp_a <= seed0;
            exp_b <= seed1;
        end else if (advance) begin
            exp_a <= next_a;
            exp_b <= next_b;
        end
    end

endmodule

// File: rtl/seq_check_monitor.sv
// Store-snooping self-check monitor. Compares each write at the expected
// address against a generated reference sequence and reports pass/fail,
// with a watchdog that ends the run if matching writes stop arriving.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | after reset, waiting for start
//   RUN   | checking writes, watchdog counting
//   DONE  | all terms seen or watchdog expired; results held
module seq_check_monitor
    import seq_chk_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter int                N_CHECK   = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(8'hFF),
    parameter bit                ADDR_DESC = 1'b1,
    parameter int                TIMEOUT   = 256,
    localparam int               CNT_W     = $clog2(N_CHECK + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed0,
    input  logic [DATA_W-1:0] seed1,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timed_out,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  first_fail_idx
);

    localparam int               WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(N_CHECK - 1);
    localparam logic [CNT_W-1:0] NO_FAIL  = CNT_W'(N_CHECK);

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] exp_addr;
    logic [CNT_W-1:0]  idx;
    logic [WD_W-1:0]   wd_cnt;
    logic [DATA_W-1:0] exp_a;
    logic              match;
    logic              last_term;
    logic              wd_expire;

    // A write coinciding with start belongs to no run and is dropped.
    assign match     = (state_q == RUN) && mem_we && (mem_addr == exp_addr) && !start;
    assign last_term = (idx == IDX_LAST);
    assign wd_expire = (state_q == RUN) && !start && !match && (wd_cnt == WD_LAST);

    seq_gen #(
        .DATA_W (DATA_W)
    ) u_seq_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (start),
        .advance (match),
        .mode    (mode_q),
        .seed0   (seed0),
        .seed1   (seed1),
        .exp_a   (exp_a)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start re-arms from anywhere; a final matching write
    // takes priority over a coincident watchdog expiry.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (match && last_term) begin
                        state_d = DONE;
                    end else if (wd_expire) begin
                        state_d = DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Address tracker, term index, tallies and watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q         <= MODE_FIB;
            exp_addr       <= BASE_ADDR;
            idx            <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= NO_FAIL;
            wd_cnt         <= '0;
            timed_out      <= 1'b0;
        end else if (start) begin
            mode_q         <= norm_mode(mode);
            exp_addr       <= BASE_ADDR;
            idx            <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= NO_FAIL;
            wd_cnt         <= '0;
            timed_out      <= 1'b0;
        end else if (state_q == RUN) begin
            if (match) begin
                if (mem_wdata == exp_a) begin
                    pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    fail_cnt <= fail_cnt + 1'b1;
                    if (first_fail_idx == NO_FAIL) begin
                        first_fail_idx <= idx;
                    end
                end
                exp_addr <= ADDR_DESC ? (exp_addr - ADDR_W'(1)) : (exp_addr + ADDR_W'(1));
                idx      <= idx + 1'b1;
                wd_cnt   <= '0;
            end else if (wd_expire) begin
                timed_out <= 1'b1;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    // Status outputs decode directly from registered state.
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign pass = done && (fail_cnt == '0) && !timed_out;

endmodule

// File: doc/seq_check_monitor.md
# seq_check_monitor

Synthesizable self-check monitor that snoops the processor's data-memory write port and compares every store against an internally generated reference sequence: Fibonacci, arithmetic or doubling. It generalises the Fibonacci result check (N values stored at descending addresses from 0xFF) to any data/address width, check depth, sequence mode and address stride. It adds a watchdog timeout, so that on-chip or FPGA runs can report pass/fail without a simulator.

## Interface
- DATA_W, 8, width of the snooped write data and of the sequence values
- ADDR_W, 8, width of the snooped address
- N_CHECK, 10, number of sequence terms to check (≥1)
- BASE_ADDR, 8'hFF, address of term 0
- ADDR_DESC, 1, 1 means term k sits at BASE_ADDR−k; 0 means BASE_ADDR+k
- TIMEOUT, 256, maximum idle cycles allowed between matching writes in RUN
- clk  in  1  single clock; everything is rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; (re)arms the checker
- mode  in  2  sampled at start: 0 Fibonacci, 1 arithmetic, 2 doubling, 3 reserved (treated as 0)
- seed0  in  DATA_W  term 0, sampled at start
- seed1  in  DATA_W  sampled at start: term 1 in mode 0, step in mode 1, ignored in mode 2
- mem_we  in  1  snooped memory write enable
- mem_addr  in  ADDR_W  snooped write address
- mem_wdata  in  DATA_W  snooped write data
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  done & fail_cnt==0 & ~timed_out
- timed_out  out  1  DONE was reached by the watchdog
- pass_cnt, fail_cnt  out  CNT_W  compare tallies, where CNT_W=$clog2(N_CHECK+1)
- first_fail_idx  out  CNT_W  index of the first mismatching term; holds N_CHECK when no term has failed

## Operation
- FSM has three states: IDLE, RUN, DONE.
- Reset (rst=1 at a clk edge): state goes to IDLE. All outputs go to 0 except first_fail_idx, which goes to N_CHECK. Reset wins over every other input, including in the middle of a RUN.
- start, from any state: state goes to RUN.
  - exp_a ← seed0, exp_b ← seed1, exp_addr ← BASE_ADDR.
  - idx, counters, watchdog and timed_out are cleared; first_fail_idx ← N_CHECK.
  - A matching write in the same cycle as start is discarded.
- In RUN, a matching write is mem_we=1 with mem_addr==exp_addr.
  - mem_wdata==exp_a increments pass_cnt. Otherwise fail_cnt increments, and first_fail_idx←idx if it still holds N_CHECK.
  - The sequence then advances; all arithmetic is mod 2^DATA_W:
    - mode 0: exp_a←exp_b, exp_b←exp_a+exp_b
    - mode 1: exp_a←exp_a+step
    - mode 2: exp_a←exp_a<<1
  - exp_addr steps by ∓1 per ADDR_DESC and wraps mod 2^ADDR_W. idx increments.
  - If idx was N_CHECK−1, the state goes to DONE.
- Non-matching writes and reads are ignored. They neither reset nor advance the watchdog state beyond normal counting.
- Watchdog:
  - It counts RUN cycles and clears on each matching write.
  - When it reaches TIMEOUT−1 with no matching write in that cycle, the state goes to DONE and timed_out←1.
  - A matching write in the expiry cycle takes priority over the timeout.
- DONE holds every output until start or rst.

## Timing
- All outputs are registered. Counters and flags reflect a matching write on the cycle after the write edge.
- done rises on the edge that samples the N_CHECK-th matching write. pass is valid in that same cycle.
- busy rises on the edge after start is sampled.
- Zero-latency back-to-back matching writes, one per cycle, must be handled.
- Timeout occurs exactly TIMEOUT cycles after the last matching write, or after start if no write has matched.

## Structure
- A shared package (seq_chk_pkg) holds:
  - the state enum: IDLE, RUN, DONE
  - the mode constants: MODE_FIB, MODE_ARITH, MODE_DBL
- One sub-module, seq_gen, is natural. It holds exp_a/exp_b and computes the next term, with load and advance strobes and the mode as inputs. The FSM, address tracker, watchdog and counters stay in the top level.

## Test plan
- Mode 0, seeds 0/1, defaults; drive 10 writes at FF..F6 with 00,01,01,02,03,05,08,0D,15,22 -> done=1, pass=1, pass_cnt=10, fail_cnt=0, first_fail_idx=10.
- Same sequence with 0x09 written at F9 -> fail_cnt=1, pass_cnt=9, first_fail_idx=6, pass=0. Interleaved stray writes to 0x40 between the good writes -> no effect on any count.
- Mode 1, seed0=0x03, step=0x07, ADDR_DESC=0, BASE_ADDR=0x10 -> expected values 03,0A,11,… at addresses 10,11,12,…; pass=1. Repeat with seed0=0xFC to confirm the data wraps to 0x03.
- BASE_ADDR=0x01, ADDR_DESC=1, N_CHECK=4 -> terms are expected at addresses 01,00,FF,FE; pass=1.
- TIMEOUT=16: start, then 3 good writes, then silence -> done with timed_out=1, pass_cnt=3, and done exactly 16 cycles after the third write.
- start pulsed again mid-RUN after 5 writes -> counters are zeroed and the check restarts at BASE_ADDR. Separately, rst asserted mid-RUN -> IDLE with all outputs at reset values on the next cycle.
